// File: rtl/io_slave_pkg.sv
// rtl/io_slave_pkg.sv - shared constants for the Avalon switch/key/LED slave
package io_slave_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_LED  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int SW_LSB = 0;

  // Keys are active-low on the board, so "released" is the idle level
  localparam logic KEY_RELEASED = 1'b1;

  function automatic int key_lsb(input int sw_w);
    return SW_LSB + sw_w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: two-flop synchronizer, debounce counter, press pulse
module key_debounce
  import io_slave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_stable,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // High in the cycle before stable falls, so the press is captured on that same edge
  assign press_pulse = stable_q & ~stable_d;
  assign key_stable  = stable_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= KEY_RELEASED;
      sync2_q  <= KEY_RELEASED;
      stable_q <= KEY_RELEASED;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/avalon_io_slave.sv
// rtl/avalon_io_slave.sv - Avalon-MM slave for switches, debounced keys with IRQ, and LEDs
module avalon_io_slave
  import io_slave_pkg::*;
#(
  parameter int SW_W            = 8,
  parameter int KEY_W           = 2,
  parameter int LED_W           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              avs_chipselect,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_irq,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [KEY_W-1:0]  key_in,
  output logic [LED_W-1:0]  led_out
);

  localparam int KEY_LSB = key_lsb(SW_W);

  logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [KEY_W-1:0] mask_q, mask_d;
  logic [KEY_W-1:0] edge_q, edge_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             irq_q, irq_d;

  logic [KEY_W-1:0] key_stable;
  logic [KEY_W-1:0] press;
  logic             wr_en, rd_en;
  logic [31:0]      rd_word;

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_raw    (key_in[i]),
      .key_stable (key_stable[i]),
      .press_pulse(press[i])
    );
  end

  assign wr_en = avs_chipselect & avs_write;
  assign rd_en = avs_chipselect & avs_read;

  // Read mux uses pre-edge register values, so a simultaneous write is not seen
  always_comb begin
    rd_word = '0;
    case (avs_address)
      ADDR_DATA: begin
        rd_word[SW_LSB +: SW_W]   = sw_s2_q;
        rd_word[KEY_LSB +: KEY_W] = ~key_stable;
      end
      ADDR_LED:  rd_word[LED_W-1:0] = led_q;
      ADDR_MASK: rd_word[KEY_W-1:0] = mask_q;
      default:   rd_word[KEY_W-1:0] = edge_q;
    endcase
  end

  always_comb begin
    sw_s1_d  = sw_in;
    sw_s2_d  = sw_s1_q;
    led_d    = led_q;
    mask_d   = mask_q;
    edge_d   = edge_q;
    rvalid_d = rd_en;
    rdata_d  = rd_en ? rd_word : rdata_q;
    irq_d    = |(edge_q & mask_q);
    if (wr_en) begin
      case (avs_address)
        ADDR_LED:  led_d  = avs_writedata[LED_W-1:0];
        ADDR_MASK: mask_d = avs_writedata[KEY_W-1:0];
        ADDR_EDGE: edge_d = edge_q & ~avs_writedata[KEY_W-1:0];
        default:   ;
      endcase
    end
    // A new press wins over a clear of the same bit
    edge_d = edge_d | press;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      led_q    <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      led_q    <= led_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign avs_irq           = irq_q;
  assign led_out           = led_q;

endmodule

// File: tb/tb_avalon_io_slave.sv
// tb/tb_avalon_io_slave.sv - scoreboard bench for avalon_io_slave (DEBOUNCE_CYCLES=4)
module tb_avalon_io_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        avs_chipselect;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_irq;
  logic [7:0]  sw_in;
  logic [1:0]  key_in;
  logic [7:0]  led_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  avalon_io_slave #(
    .SW_W(8), .KEY_W(2), .LED_W(8), .DEBOUNCE_CYCLES(4), .CNT_W(3)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs_chipselect   (avs_chipselect),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_irq          (avs_irq),
    .sw_in            (sw_in),
    .key_in           (key_in),
    .led_out          (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every valid must match the oldest outstanding read
  always @(negedge clk) begin
    if (avs_readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        check("rdata", avs_readdata, exp_q.pop_front());
      end
    end
  end

  // Tasks are entered at a negedge and return at the following negedge
  task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = addr;
    exp_q.push_back(exp);
    @(negedge clk);
    avs_chipselect = 1'b0; avs_read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = addr; avs_writedata = data;
    @(negedge clk);
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic bus_rw(input logic [1:0] addr, input logic [31:0] data, input logic [31:0] exp);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_read = 1'b1;
    avs_address = addr; avs_writedata = data;
    exp_q.push_back(exp);
    @(negedge clk);
    avs_chipselect = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; avs_chipselect = 1'b0; avs_address = 2'd0; avs_read = 1'b0;
    avs_write = 1'b0; avs_writedata = 32'd0; sw_in = 8'hA5; key_in = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_led", {24'd0, led_out}, 32'd0);
    check("rst_irq", {31'd0, avs_irq}, 32'd0);
    check("rst_rvalid", {31'd0, avs_readdatavalid}, 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    bus_read(2'd0, 32'h0000_00A5);
    check("irq_idle", {31'd0, avs_irq}, 32'd0);

    bus_write(2'd1, 32'h0000_013C);
    check("led_out", {24'd0, led_out}, 32'h3C);
    bus_read(2'd1, 32'h0000_003C);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, 32'h0000_00A5);
    avs_write = 1'b1; avs_address = 2'd1; avs_writedata = 32'h0000_00FF;
    @(negedge clk);
    avs_write = 1'b0;
    bus_read(2'd1, 32'h0000_003C);
    bus_rw(2'd1, 32'h0000_0055, 32'h0000_003C);
    bus_read(2'd1, 32'h0000_0055);
    check("led_rw", {24'd0, led_out}, 32'h55);

    // Switch path latency: two reads still see the old value, the third the new one
    sw_in = 8'h5A;
    bus_read(2'd0, 32'h0000_00A5);
    bus_read(2'd0, 32'h0000_00A5);
    bus_read(2'd0, 32'h0000_005A);

    key_in = 2'b10;
    repeat (10) @(negedge clk);
    bus_read(2'd0, 32'h0000_015A);
    bus_read(2'd3, 32'h0000_0001);
    check("irq_masked", {31'd0, avs_irq}, 32'd0);
    bus_write(2'd2, 32'h0000_0001);
    check("irq_mask_lag", {31'd0, avs_irq}, 32'd0);
    @(negedge clk);
    check("irq_unmasked", {31'd0, avs_irq}, 32'd1);
    bus_read(2'd2, 32'h0000_0001);

    key_in = 2'b11;
    repeat (10) @(negedge clk);
    key_in = 2'b01;
    repeat (3) @(negedge clk);
    key_in = 2'b11;
    repeat (10) @(negedge clk);
    bus_read(2'd0, 32'h0000_005A);
    bus_read(2'd3, 32'h0000_0001);
    check("irq_held", {31'd0, avs_irq}, 32'd1);

    // Clear lands on the same edge the new press is captured
    key_in = 2'b10;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus_write(2'd3, 32'h0000_0001);
    bus_read(2'd3, 32'h0000_0001);
    check("irq_collide", {31'd0, avs_irq}, 32'd1);
    bus_write(2'd3, 32'h0000_0001);
    check("irq_clear_lag", {31'd0, avs_irq}, 32'd1);
    @(negedge clk);
    check("irq_cleared", {31'd0, avs_irq}, 32'd0);
    bus_read(2'd3, 32'h0000_0000);

    // Reset right after a read; key0 stays held through reset
    bus_read(2'd1, 32'h0000_0055);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_rvalid", {31'd0, avs_readdatavalid}, 32'd0);
    check("mid_rst_led", {24'd0, led_out}, 32'd0);
    check("mid_rst_irq", {31'd0, avs_irq}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus_read(2'd0, 32'h0000_005A);
    bus_read(2'd0, 32'h0000_015A);
    bus_read(2'd3, 32'h0000_0001);
    bus_read(2'd2, 32'h0000_0000);
    check("irq_after_rst", {31'd0, avs_irq}, 32'd0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, 32'h0000_0003);
    check("irq_remask", {31'd0, avs_irq}, 32'd1);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_io_slave.md
Name: avalon_io_slave

Overview:
- Avalon-MM slave (responder) peripheral for the Nios II data master. It replaces generic PIOs for the board's switches, push-keys and green LEDs.
- Synchronizes the switch inputs, and synchronizes and debounces the key inputs.
- Captures key-press edges and raises a maskable interrupt.
- Drives the LEDs from a CPU-writable register.
- Instantiated in the SoC fabric alongside the SDRAM controller and exported to the top-level pins.

Parameters:
- SW_W, 8, number of switch inputs.
- KEY_W, 2, number of debounced keys (KEY[3:2]).
- LED_W, 8, number of LED outputs.
- DEBOUNCE_CYCLES, 500000, stable-input cycles needed before a key change is accepted (10 ms at 50 MHz).
- CNT_W, 19, debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk, in, 1, system clock (50 MHz).
- reset_n, in, 1, synchronous, active-low reset.
- avs_chipselect, in, 1, slave select.
- avs_address, in, 2, word address of the register.
- avs_read, in, 1, read strobe.
- avs_write, in, 1, write strobe.
- avs_writedata, in, 32, write data.
- avs_readdata, out, 32, registered read data.
- avs_readdatavalid, out, 1, asserted for the cycle in which avs_readdata is valid.
- avs_irq, out, 1, level interrupt to the CPU.
- sw_in, in, SW_W, raw switches (asynchronous).
- key_in, in, KEY_W, raw keys, active-low (0 = pressed), asynchronous.
- led_out, out, LED_W, LED drive, 1 = lit.

Behaviour:
- Clocking and reset:
  - One clock domain. All state updates on the rising edge of clk.
  - reset_n=0 at an edge resets all state regardless of the bus strobes.
- Reset values:
  - led_out=0, mask=0, edge_cap=0.
  - avs_readdata=0, avs_readdatavalid=0, avs_irq=0.
  - Key synchronizer flops and debounced key state = all 1 (released); debounce counters = 0.
  - Switch synchronizer flops = 0.
- Synchronization:
  - Two-flop synchronizer on every sw_in and key_in bit.
  - sw_sync is used directly, with no debounce; sw_in to register visibility is 2 cycles.
- Debounce, per key, independent:
  - If key_sync != key_stable: count increments.
  - Otherwise: count = 0.
  - When count reaches DEBOUNCE_CYCLES-1 with key_sync still different, key_stable <= key_sync and count <= 0 on that edge.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes key_stable.
- Edge capture:
  - A 1->0 transition of key_stable[i] (a press) sets edge_cap[i]. A release never sets it.
- Register map:
  - 0 DATA, read-only: [SW_W-1:0] = sw_sync, [SW_W+KEY_W-1:SW_W] = ~key_stable (1 = pressed), other bits 0. Writes ignored.
  - 1 LED, read/write: [LED_W-1:0]; led_out mirrors the register with no extra delay.
  - 2 IRQ_MASK, read/write: [KEY_W-1:0].
  - 3 EDGE_CAP, read / write-1-to-clear: [KEY_W-1:0].
  - Upper unused bits read 0 and ignore writes.
- Bus timing:
  - Reads have fixed latency 1. A cycle with chipselect & read loads avs_readdata, and avs_readdatavalid=1 on the following cycle only.
  - Back-to-back reads give one valid per cycle.
  - avs_readdata holds its last value when readdatavalid=0.
  - Writes take effect at the edge where chipselect & write; there is no waitrequest.
  - Strobes without chipselect have no effect.
  - read & write in the same cycle: the write is performed and the read returns the pre-write value.
- Simultaneous events: a new press edge and a W1C of the same bit in the same cycle leaves the bit set (set wins).
- Interrupt:
  - avs_irq = |(edge_cap & mask), registered, so it rises 1 cycle after edge_cap or mask changes.
  - It stays high until cleared or masked.
- Reset mid-operation:
  - A pending read in flight is dropped; readdatavalid is 0 on the cycle after reset.
  - Debounce restarts from the released state.

Decomposition:
- io_slave_pkg holds:
  - Register address constants: ADDR_DATA=2'd0, ADDR_LED=2'd1, ADDR_MASK=2'd2, ADDR_EDGE=2'd3.
  - The DATA field offsets (SW_LSB=0, KEY_LSB=SW_W).
  - The reset level constant for the keys.
- Sub-module key_debounce: one key with synchronizer, counter and stable output. It also emits a one-cycle press_pulse. It is instantiated KEY_W times via generate.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset released, read addr 0 with sw_in=8'hA5, keys released -> readdatavalid 1 cycle after the read, readdata=32'h0000_00A5; avs_irq=0.
- Write LED=32'h0000_013C -> led_out=8'h3C on the next cycle. Read addr 1 -> 32'h0000_003C.
- key_in[0] held low 10 cycles -> DATA bit 8 = 1 and EDGE_CAP=2'b01. With MASK=0, avs_irq stays 0. Write MASK=1 -> avs_irq=1 one cycle later.
- key_in[1] low-glitch for 3 cycles, then high -> key_stable unchanged, EDGE_CAP bit 1 = 0, no interrupt.
- EDGE_CAP=2'b01, IRQ on; write 32'h1 to addr 3 in the same cycle as a new key0 press edge -> bit stays 1 and IRQ stays 1. A second write of 32'h1 without a press -> EDGE_CAP=0, avs_irq=0 one cycle later.
- Assert reset_n=0 the cycle after a read strobe -> readdatavalid=0, led_out=0, mask=0, edge_cap=0. Debounce counters restart, and the next press needs a full DEBOUNCE_CYCLES.
